// File: rtl/xled_ctrl.sv
// xled_ctrl: memory-mapped LED peripheral with static, blink and 8-bit PWM modes.
//
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   sel       - peripheral select from the address decoder
//   we        - write enable, qualified by sel
//   addr      - register offset: 0 VALUE, 1 MODE, 2 PERIOD, 3 DUTY
//   data_in   - write data; only the low register-width bits are kept
//   data_out  - combinational, zero-extended read of the addressed register
//   led       - registered LED drive
module xled_ctrl #(
  parameter int unsigned N_LEDS = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic [N_LEDS-1:0] led
);

  typedef enum logic [1:0] {
    ModeStatic = 2'd0,
    ModeBlink  = 2'd1,
    ModePwm    = 2'd2,
    ModeRsvd   = 2'd3
  } mode_e;

  localparam logic [1:0] AddrValue  = 2'd0;
  localparam logic [1:0] AddrMode   = 2'd1;
  localparam logic [1:0] AddrPeriod = 2'd2;
  localparam logic [1:0] AddrDuty   = 2'd3;

  logic [N_LEDS-1:0] value_q, value_d;
  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [7:0]        duty_q, duty_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic              phase_q, phase_d;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;
  logic [N_LEDS-1:0] led_q, led_d;

  logic wr_en;
  logic restart;
  logic tick;

  // Upper data_in bits are intentionally discarded.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  assign wr_en   = sel & we;
  assign restart = wr_en & ((addr == AddrMode) | (addr == AddrPeriod));
  assign tick    = (pcnt_q == period_q);

  always_comb begin
    value_d  = value_q;
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    if (wr_en) begin
      unique case (addr)
        AddrValue:  value_d  = data_in[N_LEDS-1:0];
        AddrMode:   mode_d   = mode_e'(data_in[1:0]);
        AddrPeriod: period_d = data_in[CNT_W-1:0];
        AddrDuty:   duty_d   = data_in[7:0];
        default:    ;
      endcase
    end
  end

  // A restart beats a coincident tick: counters clear with no toggle/increment.
  always_comb begin
    pcnt_d    = pcnt_q + CNT_W'(1);
    phase_d   = phase_q;
    pwm_cnt_d = pwm_cnt_q;
    if (restart) begin
      pcnt_d    = '0;
      phase_d   = 1'b0;
      pwm_cnt_d = '0;
    end else if (tick) begin
      pcnt_d    = '0;
      phase_d   = ~phase_q;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
  end

  // LED drive uses the state settled at the previous edge, so it lags a tick by one cycle.
  always_comb begin
    led_d = '0;
    unique case (mode_q)
      ModeStatic: led_d = value_q;
      ModeBlink:  led_d = phase_q ? value_q : '0;
      ModePwm:    led_d = (pwm_cnt_q < duty_q) ? value_q : '0;
      ModeRsvd:   led_d = '0;
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q   <= '0;
      mode_q    <= ModeStatic;
      period_q  <= '0;
      duty_q    <= '0;
      pcnt_q    <= '0;
      phase_q   <= 1'b0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      value_q   <= value_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      pcnt_q    <= pcnt_d;
      phase_q   <= phase_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    data_out = '0;
    unique case (addr)
      AddrValue:  data_out[N_LEDS-1:0] = value_q;
      AddrMode:   data_out[1:0]        = mode_q;
      AddrPeriod: data_out[CNT_W-1:0]  = period_q;
      AddrDuty:   data_out[7:0]        = duty_q;
      default:    data_out = '0;
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_xled_ctrl.sv
// Self-checking bench for xled_ctrl: a cycle model pushes expected led/data_out
// per edge into a queue, popped and compared just after the edge.
module tb_xled_ctrl;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [7:0]  led;

  xled_ctrl #(
    .N_LEDS(8),
    .CNT_W (16)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  led;
    logic [31:0] dout;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (what the peripheral should hold after the last edge).
  logic [7:0]  m_value;
  logic [1:0]  m_mode;
  logic [15:0] m_period;
  logic [7:0]  m_duty;
  logic [15:0] m_pcnt;
  logic        m_phase;
  logic [7:0]  m_pwm;
  logic [7:0]  m_led;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_value};
      2'd1:    return {30'd0, m_mode};
      2'd2:    return {16'd0, m_period};
      default: return {24'd0, m_duty};
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [7:0] led_n;
    logic       wr;
    if (rst) begin
      m_value = 0; m_mode = 0; m_period = 0; m_duty = 0;
      m_pcnt = 0; m_phase = 0; m_pwm = 0; m_led = 0;
      return;
    end
    case (m_mode)
      2'd0:    led_n = m_value;
      2'd1:    led_n = m_phase ? m_value : 8'd0;
      2'd2:    led_n = (m_pwm < m_duty) ? m_value : 8'd0;
      default: led_n = 8'd0;
    endcase
    wr = sel && we;
    if (wr && (addr == 2'd1 || addr == 2'd2)) begin
      m_pcnt = 0; m_phase = 0; m_pwm = 0;
    end else if (m_pcnt == m_period) begin
      m_pcnt = 0; m_phase = !m_phase; m_pwm = m_pwm + 8'd1;
    end else begin
      m_pcnt = m_pcnt + 16'd1;
    end
    if (wr) begin
      case (addr)
        2'd0:    m_value  = data_in[7:0];
        2'd1:    m_mode   = data_in[1:0];
        2'd2:    m_period = data_in[15:0];
        default: m_duty   = data_in[7:0];
      endcase
    end
    m_led = led_n;
  endtask

  task automatic cycle();
    exp_t e;
    model_edge();
    exp_q.push_back('{led: m_led, dout: model_read(addr)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("led", {24'd0, led}, {24'd0, e.led});
    check("data_out", data_out, e.dout);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    cycle();
    we = 1'b0; sel = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    cycle();
    check(tag, data_out, exp);
  endtask

  task automatic count_on(input int n, input logic [7:0] pat, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (led === pat) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int guard;
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;

    // Reset and readback.
    run(2);
    rst = 1'b0;
    reg_read(2'd0, 32'd0, "rst_value");
    reg_read(2'd1, 32'd0, "rst_mode");
    reg_read(2'd2, 32'd0, "rst_period");
    reg_read(2'd3, 32'd0, "rst_duty");
    check("rst_led", {24'd0, led}, 32'd0);

    // Static VALUE write, upper bits discarded.
    reg_write(2'd0, 32'hFFFF_FFA5);
    check("value_rd", data_out, 32'h0000_00A5);
    cycle();
    check("static_led", {24'd0, led}, 32'h0000_00A5);

    // Blink: 8-cycle period starting low.
    reg_write(2'd0, 32'h0F);
    reg_write(2'd2, 32'd3);
    reg_write(2'd1, 32'd1);
    count_on(4, 8'h00, cnt);
    check("blink_low_run", cnt, 4);
    count_on(4, 8'h0F, cnt);
    check("blink_high_run", cnt, 4);
    count_on(16, 8'h0F, cnt);
    check("blink_duty", cnt, 8);

    // Restart collision: rewrite PERIOD exactly in the tick cycle.
    reg_write(2'd2, 32'd2);
    guard = 0;
    while (m_pcnt != 16'd2 && guard < 20) begin
      cycle();
      guard++;
    end
    check("pcnt_wait", {16'd0, m_pcnt}, 32'd2);
    reg_write(2'd2, 32'd5);
    count_on(6, 8'h00, cnt);
    check("restart_low", cnt, 6);
    count_on(6, 8'h0F, cnt);
    check("restart_high", cnt, 6);
    run(6);

    // PWM dimming at DUTY 64, 0 and 255.
    reg_write(2'd0, 32'hFF);
    reg_write(2'd2, 32'd0);
    reg_write(2'd3, 32'd64);
    reg_write(2'd1, 32'd2);
    count_on(256, 8'hFF, cnt);
    check("pwm_64", cnt, 64);
    reg_write(2'd3, 32'd0);
    run(2);
    count_on(256, 8'hFF, cnt);
    check("pwm_0", cnt, 0);
    reg_write(2'd3, 32'd255);
    run(2);
    count_on(256, 8'hFF, cnt);
    check("pwm_255", cnt, 255);

    // Select gating: write with sel low is ignored.
    sel = 1'b0; we = 1'b1; addr = 2'd0; data_in = 32'h55;
    cycle();
    we = 1'b0;
    check("sel_gate", data_out, 32'hFF);

    // Reserved mode blanks the LEDs.
    reg_write(2'd1, 32'd3);
    run(8);
    check("mode3_led", {24'd0, led}, 32'd0);

    // Reset in the middle of a blink high phase.
    reg_write(2'd0, 32'h0F);
    reg_write(2'd2, 32'd3);
    reg_write(2'd1, 32'd1);
    guard = 0;
    while (led !== 8'h0F && guard < 20) begin
      cycle();
      guard++;
    end
    check("blink_high", {24'd0, led}, 32'h0F);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_led", {24'd0, led}, 32'd0);
    reg_read(2'd0, 32'd0, "midrst_value");
    reg_read(2'd1, 32'd0, "midrst_mode");
    reg_read(2'd2, 32'd0, "midrst_period");
    reg_read(2'd3, 32'd0, "midrst_duty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard timeout so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xled_ctrl.md
# xled_ctrl

Memory-mapped LED peripheral downstream of the address decoder's `led_sel` output. It holds an LED value register and drives the board LEDs in one of three modes: static, blink and 8-bit PWM dimming. A programmable prescaler sets the blink and PWM rates. All register reads are combinational and returned through `data_out`, so software can read back the configuration.

## Interface
- `N_LEDS`, default 8: number of LED outputs; width of the VALUE register (max 32).
- `CNT_W`, default 16: width of the PERIOD register and the prescaler counter.

- `clk`, input, 1: system clock; single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `sel`, input, 1: peripheral select, driven by the decoder's `led_sel`.
- `we`, input, 1: write enable; qualified by `sel`.
- `addr`, input, 2: register offset (low address bits).
- `data_in`, input, 32: write data.
- `data_out`, output, 32: combinational read data for `addr`, zero-extended.
- `led`, output, N_LEDS: registered LED drive.

## Operation
- Register map:
  - 0 = VALUE[N_LEDS-1:0]
  - 1 = MODE[1:0]: 0 static, 1 blink, 2 PWM, 3 reserved
  - 2 = PERIOD[CNT_W-1:0]
  - 3 = DUTY[7:0]
- Writes:
  - On a `clk` edge with `sel & we`, the addressed register loads the low bits of `data_in`; upper bits are discarded.
  - With `sel=0`, writes are ignored.
- Reads:
  - `data_out` = addressed register, zero-extended, independent of `sel` and `we`.
- Prescaler:
  - `pcnt` counts 0..PERIOD.
  - `tick`=1 in the cycle `pcnt==PERIOD`; `pcnt` then wraps to 0.
  - PERIOD=0 gives a tick every cycle.
- Blink:
  - `phase` toggles on each tick.
  - `led` = `phase` ? VALUE : 0.
- PWM:
  - 8-bit `pwm_cnt` increments on each tick and wraps 255→0.
  - `led` = (`pwm_cnt` < DUTY) ? VALUE : 0.
  - DUTY=0 gives always off; DUTY=255 gives on 255 of every 256 steps.
- Static: `led` = VALUE.
- Reserved mode 3: `led` = 0; counters keep running.
- Restart: a write to MODE or PERIOD clears `pcnt`, `phase` and `pwm_cnt` on the same edge.
  - This restart wins over a coincident tick: no toggle, no increment.
- Writes to VALUE or DUTY do not disturb the counters.
- The counters run in every mode, including static.

## Timing
- Reset (`rst`=1 at an edge):
  - VALUE, MODE, PERIOD, DUTY, `pcnt`, `phase`, `pwm_cnt` all = 0.
  - `led` = 0.
  - Reset has priority over a simultaneous write.
- Write latency: the register updates at edge E0 (end of the write cycle). `led` reflects the new value at edge E1. `data_out` reflects it immediately after E0.
- `led` is a register computed from the post-E0 register and counter state.
  - Blink output therefore changes one cycle after the tick cycle.
- Blink period is 2·(PERIOD+1) cycles: high for PERIOD+1 cycles, low for PERIOD+1 cycles. The first high phase starts after the first tick following a restart.
- PWM frame is 256·(PERIOD+1) cycles.
- Mid-operation reset: every state returns to reset values at that edge, and `led`=0 from that edge.
- No handshake or stall: every access completes in the cycle it is presented.

## Test plan
- Reset/readback: assert `rst` for 2 cycles, then read all 4 addresses → 0, and `led`=0. Write VALUE=0xFFFF_FFA5 → read 0xA5, `led`=0xA5 one cycle after the write edge.
- Blink: VALUE=0x0F, PERIOD=3, MODE=1 → `led` alternates 0x0F/0x00 every 4 cycles (period 8), starting from 0x00 after the MODE write.
- PWM: VALUE=0xFF, PERIOD=0, DUTY=64, MODE=2 → over a 256-cycle window `led`=0xFF for exactly 64 cycles. Repeat with DUTY=0 (never on) and DUTY=255 (255 on).
- Restart collision: PERIOD=2 in blink mode; write PERIOD=5 in the cycle `pcnt==2` → no toggle that cycle, `pcnt` reads as restarted, next toggle 6 cycles later.
- Select gating: `we`=1, `sel`=0, `addr`=0, `data_in`=0x55 → VALUE unchanged. Mode 3 → `led`=0 regardless of VALUE.
- Reset mid-blink: with `led`=0x0F high, assert `rst` for 1 cycle → `led`=0 and all registers 0 at that edge.
